// File: rtl/spi_apb_bridge.sv
// SPI mode-0 slave that decodes 3-byte write / 4-byte read frames and issues one APB transfer per frame.
// The SPI pins are oversampled in the PCLK domain; this is the only master on the APB bus.
module spi_apb_bridge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       PCLK,
  input  logic       PRESETn,
  input  logic       SPI_SCK,
  input  logic       SPI_CS_N,
  input  logic       SPI_MOSI,
  output logic       SPI_MISO,
  output logic       SPI_MISO_OE,
  output logic       PSEL,
  output logic       PENABLE,
  output logic       PWRITE,
  output logic [7:0] PADDR,
  output logic [7:0] PWDATA,
  input  logic [7:0] PRDATA,
  input  logic       PREADY,
  output logic       BUSY
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;

  logic [SYNC_STAGES-1:0] r_sck_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_sck_d;
  logic                   r_cs_d;
  logic                   r_active;
  logic [5:0]             r_bit_cnt;
  logic [7:0]             r_shift;
  logic                   r_cmd_wr;
  logic [7:0]             r_addr;
  logic [7:0]             r_tx;
  logic [7:0]             r_tx_sh;
  logic                   r_rd_pend;
  logic                   r_rd_done;
  logic                   r_miso;
  logic                   r_miso_oe;
  logic [1:0]             r_state;
  logic                   r_pwrite;
  logic [7:0]             r_paddr;
  logic [7:0]             r_pwdata;

  logic       w_sck;
  logic       w_cs_n;
  logic       w_mosi;
  logic       w_cs_fall;
  logic       w_cs_rise;
  logic       w_rise;
  logic       w_fall;
  logic [5:0] w_cnt_next;
  logic [7:0] w_byte;
  logic       w_req_wr;
  logic       w_req_rd;
  logic       w_start;
  logic       w_rd_ack;
  logic [7:0] w_tx_load;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_sck_sync  <= '0;
      r_cs_sync   <= '1;
      r_mosi_sync <= '0;
      r_sck_d     <= 1'b0;
      r_cs_d      <= 1'b1;
    end else begin
      r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], SPI_SCK};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], SPI_CS_N};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], SPI_MOSI};
      r_sck_d     <= w_sck;
      r_cs_d      <= w_cs_n;
    end
  end

  assign w_sck      = r_sck_sync[SYNC_STAGES-1];
  assign w_cs_n     = r_cs_sync[SYNC_STAGES-1];
  assign w_mosi     = r_mosi_sync[SYNC_STAGES-1];
  assign w_cs_fall  = ~w_cs_n & r_cs_d;
  assign w_cs_rise  = w_cs_n & ~r_cs_d;
  assign w_rise     = r_active & w_sck & ~r_sck_d;
  assign w_fall     = r_active & ~w_sck & r_sck_d;
  // Saturate so that overlong frames can never re-hit the 16/24 trigger counts.
  assign w_cnt_next = (r_bit_cnt == 6'h3F) ? r_bit_cnt : r_bit_cnt + 6'd1;
  assign w_byte     = {r_shift[6:0], w_mosi};
  assign w_req_wr   = w_rise & (w_cnt_next == 6'd24) & r_cmd_wr;
  assign w_req_rd   = w_rise & (w_cnt_next == 6'd16) & ~r_cmd_wr;
  assign w_start    = (w_req_wr | w_req_rd) & (r_state == ST_IDLE);
  assign w_rd_ack   = (r_state == ST_ACCESS) & PREADY & ~r_pwrite;
  assign w_tx_load  = r_rd_done ? r_tx : 8'hFF;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_active  <= 1'b0;
      r_bit_cnt <= 6'd0;
      r_shift   <= 8'h00;
      r_cmd_wr  <= 1'b0;
      r_addr    <= 8'h00;
      r_tx_sh   <= 8'h00;
      r_miso    <= 1'b0;
      r_miso_oe <= 1'b0;
    end else if (w_cs_fall) begin
      r_active  <= 1'b1;
      r_bit_cnt <= 6'd0;
      r_shift   <= 8'h00;
      r_cmd_wr  <= 1'b0;
      r_miso    <= 1'b0;
      r_miso_oe <= 1'b1;
    end else if (w_cs_rise) begin
      r_active  <= 1'b0;
      r_miso    <= 1'b0;
      r_miso_oe <= 1'b0;
    end else begin
      if (w_rise) begin
        r_shift   <= w_byte;
        r_bit_cnt <= w_cnt_next;
        if (w_cnt_next == 6'd8)  r_cmd_wr <= w_byte[7];
        if (w_cnt_next == 6'd16) r_addr   <= w_byte;
      end
      // Byte 3 of a read: the fall after rise 24 is the late-read cutoff.
      if (w_fall) begin
        if (!r_cmd_wr && r_bit_cnt == 6'd24) begin
          r_miso  <= w_tx_load[7];
          r_tx_sh <= {w_tx_load[6:0], 1'b0};
        end else if (!r_cmd_wr && r_bit_cnt > 6'd24 && r_bit_cnt < 6'd32) begin
          r_miso  <= r_tx_sh[7];
          r_tx_sh <= {r_tx_sh[6:0], 1'b0};
        end else begin
          r_miso  <= 1'b0;
        end
      end
    end
  end

  // A transfer left over from an aborted frame must not count as this frame's read.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_rd_pend <= 1'b0;
      r_rd_done <= 1'b0;
      r_tx      <= 8'h00;
    end else begin
      if (w_rd_ack) r_tx <= PRDATA;
      if (w_cs_fall) begin
        r_rd_pend <= 1'b0;
        r_rd_done <= 1'b0;
      end else if (w_start && w_req_rd) begin
        r_rd_pend <= 1'b1;
        r_rd_done <= 1'b0;
      end else if (w_rd_ack && r_rd_pend) begin
        r_rd_pend <= 1'b0;
        r_rd_done <= 1'b1;
      end
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state  <= ST_IDLE;
      r_pwrite <= 1'b0;
      r_paddr  <= 8'h00;
      r_pwdata <= 8'h00;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_state  <= ST_SETUP;
            r_pwrite <= w_req_wr;
            r_paddr  <= w_req_wr ? r_addr : w_byte;
            if (w_req_wr) r_pwdata <= w_byte;
          end
        end
        ST_SETUP:  r_state <= ST_ACCESS;
        ST_ACCESS: if (PREADY) r_state <= ST_IDLE;
        default:   r_state <= ST_IDLE;
      endcase
    end
  end

  assign PSEL        = (r_state != ST_IDLE);
  assign PENABLE     = (r_state == ST_ACCESS);
  assign BUSY        = (r_state != ST_IDLE);
  assign PWRITE      = r_pwrite;
  assign PADDR       = r_paddr;
  assign PWDATA      = r_pwdata;
  assign SPI_MISO    = r_miso;
  assign SPI_MISO_OE = r_miso_oe;

endmodule

// File: doc/spi_apb_bridge.md
# spi_apb_bridge

SPI-slave to APB-master bridge feeding the debug status register and other 8-bit APB peripherals from an external host. Decodes 3-byte write and 4-byte read frames, oversampled entirely in the PCLK domain, and issues one APB transfer per frame. Sits directly upstream of the debug/status APB slaves. It is the only APB master on the bus.

## Interface
- SYNC_STAGES, 2, synchroniser depth on SPI_SCK, SPI_CS_N and SPI_MOSI (≥2)
- PCLK  in  1  system clock; all logic on rising edge
- PRESETn  in  1  asynchronous active-low reset
- SPI_SCK  in  1  host serial clock, SPI mode 0 (CPOL=0, CPHA=0), asynchronous to PCLK
- SPI_CS_N  in  1  host chip select, active low; frame boundary
- SPI_MOSI  in  1  host data, MSB first
- SPI_MISO  out  1  bridge data, MSB first
- SPI_MISO_OE  out  1  pad output enable for SPI_MISO
- PSEL, PENABLE, PWRITE  out  1 each  APB control
- PADDR  out  8  APB address
- PWDATA  out  8  APB write data
- PRDATA  in  8  APB read data
- PREADY  in  1  APB ready; extends the ACCESS phase while low
- BUSY  out  1  high while the APB FSM is not IDLE

## Operation
- Reset: PSEL, PENABLE, PWRITE, BUSY, SPI_MISO, SPI_MISO_OE = 0; PADDR, PWDATA = 0x00; bit/byte counters cleared; APB FSM IDLE.
- SCK, CS_N and MOSI each pass through SYNC_STAGES flops. Edge detection on the synchronised SCK. MOSI sampled on a detected rise; MISO updated on a detected fall.
- Frame start: synchronised CS_N falls; counters clear; SPI_MISO_OE=1 and SPI_MISO=0.
- Frame end: synchronised CS_N rises; SPI_MISO_OE=0 and SPI_MISO=0.
- Byte 0 is the command. Bit 7: 1=write, 0=read. Bits 6:0 ignored.
- Byte 1 is the address and is latched to the PADDR staging register.
- Write frame: byte 2 is data. After the 24th rise, request APB write (PADDR, PWDATA=byte 2).
- Read frame:
  - After the 16th rise, request APB read of PADDR.
  - Byte 2 is a dummy; MOSI is ignored.
  - Byte 3 shifts out the read result. Its MSB is driven on the fall following the 24th rise; remaining bits follow on subsequent falls.
- Read data capture: PRDATA is latched into the TX register in the ACCESS cycle where PREADY=1.
- Late read: if the read has not completed by the fall after the 24th rise, byte 3 returns 0xFF and the late PRDATA is discarded.
- SPI_MISO is 0 during bytes 0-2 and after the frame's final byte.
- Bytes beyond the frame length are ignored; no further APB transfers.
- CS_N rises mid-frame: the frame is aborted and no request is issued. An APB transfer already in SETUP/ACCESS runs to completion; APB is never truncated.
- APB FSM states:
  - IDLE: PSEL=0, PENABLE=0. Goes to SETUP on a request.
  - SETUP: PSEL=1, PENABLE=0, 1 cycle. Then ACCESS.
  - ACCESS: PSEL=1, PENABLE=1. Holds until PREADY=1, then IDLE.
  - PADDR, PWRITE and PWDATA are stable from SETUP through the end of ACCESS.
- Requests are never issued back-to-back, so PENABLE is low for at least one cycle between transfers. Downstream slaves edge-detect PENABLE and rely on this.
- Request arriving while the FSM is not IDLE: dropped, no queueing.
- Asynchronous reset mid-transfer: all outputs return to reset values immediately; the host must restart the frame.

## Timing
- Host constraints, all in PCLK cycles:
  - SCK high ≥ 4 and SCK low ≥ 4.
  - CS_N fall to first SCK rise ≥ 4.
  - Last SCK fall to CS_N rise ≥ 4.
  - CS_N high between frames ≥ 4.
- Pin-edge to action latency: SYNC_STAGES+1 PCLK cycles (3 at default).
- Write frame, PREADY=1: SETUP is the cycle after the 24th rise is detected; ACCESS follows; IDLE on the next cycle. Total: 2 cycles with PSEL=1.
- Read frame: SETUP is the cycle after the 16th rise is detected. With the minimum SCK timing, the dummy byte leaves ≥ 56 PCLK cycles of PREADY wait before the late-read cutoff.
- BUSY is high from the SETUP cycle through the final ACCESS cycle inclusive.

## Test plan
- Write frame 0x80,0x00,0x01 with PREADY=1 -> one SETUP/ACCESS pair with PADDR=0x00, PWDATA=0x01, PWRITE=1; PSEL high for exactly 2 cycles.
- Read frame 0x00,0x00,0x00,0x00 with PRDATA=0x0A, PREADY=1 -> APB read of 0x00; byte 3 on MISO=0x0A; MISO=0 during bytes 0-2.
- Read with PREADY held low for 10 cycles -> ACCESS held 10 cycles, then PRDATA=0x5C returned in byte 3. Same read with PREADY low past the cutoff -> byte 3=0xFF, and the FSM still completes.
- Write frame aborted by CS_N rise after 20 bits -> no PSEL. The next complete write executes normally.
- Two back-to-back write frames at minimum host timing -> two distinct transfers with PENABLE low ≥ 1 cycle between them.
- Assert PRESETn low during ACCESS -> PSEL=PENABLE=BUSY=0 immediately. The following frame after reset release executes correctly.
